// File: rtl/pq_pkg.sv
// Shared types and constants for the priority-queue drain block.
//  KEY_WIDTH / VAL_WIDTH / KV_WIDTH : geometry of one queue entry
//  kv_t           : packed {key, val}. The key occupies the upper bits.
//  drain_state_t  : drain FSM states
//  key_out_of_order() : key-ordering rule used by the order checker
package pq_pkg;

  localparam int KEY_WIDTH = 8;
  localparam int VAL_WIDTH = 8;
  localparam int KV_WIDTH  = KEY_WIDTH + VAL_WIDTH;

  typedef struct packed {
    logic [KEY_WIDTH-1:0] key;
    logic [VAL_WIDTH-1:0] val;
  } kv_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } drain_state_t;

  // True when cur breaks the ordering against the previous key. Keys are unsigned.
  // Equal keys are never a violation.
  function automatic logic key_out_of_order(input logic [KEY_WIDTH-1:0] last_key,
                                            input logic [KEY_WIDTH-1:0] cur_key,
                                            input logic                 min_first);
    return min_first ? (cur_key < last_key) : (cur_key > last_key);
  endfunction

endpackage

// File: rtl/pq_skid2.sv
// Two-entry FIFO skid buffer of kv_t with a valid/ready output.
//  clk, rst        : clock and synchronous active-high reset
//  push, push_kv   : write one entry this cycle. The caller must respect slots_free.
//  out_valid       : buffer non-empty
//  out_ready       : downstream takes out_kv this cycle
//  out_kv          : oldest entry
//  slots_free      : room for a push this cycle. It includes an entry leaving on this
//                    same cycle's handshake, so a full buffer with out_ready=1 still
//                    accepts one push.
module pq_skid2
  import pq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  kv_t        push_kv,
  output logic       out_valid,
  input  logic       out_ready,
  output kv_t        out_kv,
  output logic [1:0] slots_free
);

  kv_t        head_q;   // oldest entry, drives out_kv
  kv_t        tail_q;   // second entry, valid only when count_q == 2
  logic [1:0] count_q;
  logic       pop;

  assign out_valid  = (count_q != 2'd0);
  assign out_kv     = head_q;
  assign pop        = out_valid && out_ready;
  assign slots_free = 2'd2 - count_q + {1'b0, pop};

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data registers are reset as well as the count, so out_kv reads
      // zero after reset and not a stale pair.
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      if (pop) begin
        if (count_q == 2'd2) begin
          head_q <= tail_q;
          if (push) tail_q <= push_kv;
        end else if (push) begin
          head_q <= push_kv;
        end
      end else if (push) begin
        if (count_q == 2'd0) head_q <= push_kv;
        else                 tail_q <= push_kv;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/pq_drain.sv
// Dequeue-side master for the shift-register priority queue.
// It pops the queue head whenever the skid buffer has room. The popped pairs stream out
// through a 2-entry valid/ready buffer. A drain runs either continuously (burst_len = 0)
// until stop, or for a counted burst.
// order_err is a sticky flag. It is set when a pop breaks key order against the previous
// pop, and only if no enqueue happened in between.
//  clk, rst            : clock and synchronous active-high reset
//  start, burst_len    : begin a drain from IDLE. burst_len = 0 means continuous.
//  stop                : end a continuous drain or abort a burst
//  pq_empty, pq_kvo    : queue status and head {key,val}
//  pq_enq              : enqueue strobe seen by the queue. Only monitored here.
//  pq_deq              : pop the head this cycle. pq_kvo is captured at this edge.
//  out_valid, out_ready, out_kv : popped-pair stream
//  busy, done, order_err        : status
module pq_drain
  import pq_pkg::*;
#(
  parameter int BURST_W   = 8,
  parameter bit MIN_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [BURST_W-1:0]  burst_len,
  input  logic                stop,
  input  logic                pq_empty,
  input  logic [KV_WIDTH-1:0] pq_kvo,
  input  logic                pq_enq,
  output logic                pq_deq,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [KV_WIDTH-1:0] out_kv,
  output logic                busy,
  output logic                done,
  output logic                order_err
);

  drain_state_t         state_q;
  logic [BURST_W-1:0]   len_q;       // burst length latched at start
  logic [BURST_W-1:0]   cnt_q;       // pops issued in this drain
  logic [KEY_WIDTH-1:0] base_key_q;  // key of the previous pop
  logic                 base_valid_q;
  logic [1:0]           slots_free;
  logic                 last_pop;
  logic [KEY_WIDTH-1:0] pop_key;
  kv_t                  buf_kv;

  assign pop_key = pq_kvo[KV_WIDTH-1 -: KEY_WIDTH];

  // stop wins over a pop in the same cycle. rst removes the pop immediately, so the
  // queue never loses an entry that the buffer is about to discard.
  assign pq_deq = !rst && (state_q == S_RUN) && !pq_empty && (slots_free != 2'd0) && !stop
                  && ((len_q == '0) || (cnt_q < len_q));

  assign last_pop = pq_deq && (len_q != '0) && (cnt_q + BURST_W'(1) == len_q);

  pq_skid2 u_skid (
    .clk        (clk),
    .rst        (rst),
    .push       (pq_deq),
    .push_kv    (kv_t'(pq_kvo)),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_kv     (buf_kv),
    .slots_free (slots_free)
  );

  assign out_kv = buf_kv;

  // Drain FSM. busy and done are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_RUN;
            busy    <= 1'b1;
            len_q   <= burst_len;
            cnt_q   <= '0;
          end
        end
        S_RUN: begin
          if (pq_deq) cnt_q <= cnt_q + BURST_W'(1);
          if (stop || last_pop) begin
            state_q <= S_DONE;
            done    <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Order checker. The baseline follows the latest pop. An enqueue may legally place a
  // smaller or larger key at the head, so an enqueue drops the baseline.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_key_q   <= '0;
      base_valid_q <= 1'b0;
      order_err    <= 1'b0;
    end else begin
      if (pq_deq) begin
        if (base_valid_q && key_out_of_order(base_key_q, pop_key, MIN_FIRST))
          order_err <= 1'b1;
        base_key_q   <= pop_key;
        base_valid_q <= 1'b1;
      end
      // NOTE: the last non-blocking assignment to a register wins. An enqueue therefore
      // invalidates the baseline even in a cycle that also pops. That cycle's compare
      // has already used the old value.
      if (pq_enq) base_valid_q <= 1'b0;
    end
  end

endmodule
